// File: rtl/boreal_mailbox_phaseb.sv
// Phase-B request/response mailbox between the decision VM and the policy executor.
// Optional nonce check of response word 4 against request word 7: define BOREAL_MB_NONCE_CHECK_EN.
module boreal_mailbox_phaseb #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] TIMEOUT_CODE   = 32'hDEAD_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vm_req_we,
   input  logic [3:0]  vm_req_widx,
   input  logic [31:0] vm_req_wdata,
   input  logic        vm_req_valid_set,
   output logic        vm_resp_valid,
   output logic [31:0] vm_resp_w0,
   output logic [31:0] vm_resp_w1,
   output logic [31:0] vm_resp_w2,
   output logic [31:0] vm_resp_w3,
   output logic [31:0] vm_resp_w4,
   input  logic        vm_resp_ack,
   output logic        exec_req_valid,
   input  logic        exec_req_ready,
   output logic [31:0] exec_req_word,
   output logic        exec_req_last,
   input  logic        exec_resp_valid,
   output logic        exec_resp_ready,
   input  logic [31:0] exec_resp_word,
   input  logic        exec_resp_last,
   output logic        busy,
   output logic [3:0]  status
);

   localparam int unsigned DW         = 32;
   localparam int unsigned REQ_WORDS  = 8;
   localparam int unsigned RESP_WORDS = 5;
   localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`ifdef BOREAL_MB_NONCE_CHECK_EN
   localparam logic [31:0] NONCE_ERR_CODE = 32'hDEAD_0002;
`endif

   typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, RESP_READY} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    req_q  [REQ_WORDS];
   logic [DW-1:0]    req_d  [REQ_WORDS];
   logic [DW-1:0]    resp_q [RESP_WORDS];
   logic [DW-1:0]    resp_d [RESP_WORDS];
   logic [2:0]       send_idx_q, send_idx_d;
   logic [2:0]       rcv_idx_q, rcv_idx_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [3:0]       status_q, status_d;
   logic             req_valid_q, req_valid_d;
   logic [DW-1:0]    req_word_q, req_word_d;
   logic             req_last_q, req_last_d;
   logic             resp_ready_q, resp_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic             busy_q, busy_d;

   // State and datapath registers; every output is a flop so reset clears it asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= '{default: '0};
         resp_q       <= '{default: '0};
         send_idx_q   <= '0;
         rcv_idx_q    <= '0;
         idle_cnt_q   <= '0;
         status_q     <= '0;
         req_valid_q  <= 1'b0;
         req_word_q   <= '0;
         req_last_q   <= 1'b0;
         resp_ready_q <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         resp_q       <= resp_d;
         send_idx_q   <= send_idx_d;
         rcv_idx_q    <= rcv_idx_d;
         idle_cnt_q   <= idle_cnt_d;
         status_q     <= status_d;
         req_valid_q  <= req_valid_d;
         req_word_q   <= req_word_d;
         req_last_q   <= req_last_d;
         resp_ready_q <= resp_ready_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      resp_d     = resp_q;
      send_idx_d = send_idx_q;
      rcv_idx_d  = rcv_idx_q;
      idle_cnt_d = idle_cnt_q;
      status_d   = status_q;

      case (state_q)
         IDLE: begin
            if (vm_req_we && !vm_req_widx[3]) req_d[vm_req_widx[2:0]] = vm_req_wdata;
            if (vm_req_valid_set) begin
               state_d    = SEND;
               send_idx_d = '0;
            end
         end
         SEND: begin
            if (exec_req_ready) begin
               if (send_idx_q == 3'd7) begin
                  send_idx_d = '0;
                  rcv_idx_d  = '0;
                  idle_cnt_d = '0;
                  state_d    = WAIT_RESP;
               end else begin
                  send_idx_d = send_idx_q + 3'd1;
               end
            end
         end
         WAIT_RESP: begin
            if (exec_resp_valid) begin
               resp_d[rcv_idx_q] = exec_resp_word;
               rcv_idx_d         = rcv_idx_q + 3'd1;
               idle_cnt_d        = '0;
               if (rcv_idx_q == 3'd4 || exec_resp_last) begin
                  // Early last: zero the words the executor never sent.
                  if (rcv_idx_q != 3'd4) begin
                     status_d[1] = 1'b1;
                     for (int unsigned i = 0; i < RESP_WORDS; i++)
                        if (i > 32'(rcv_idx_q)) resp_d[i] = '0;
                  end
                  rcv_idx_d = '0;
                  state_d   = RESP_READY;
`ifdef BOREAL_MB_NONCE_CHECK_EN
                  if (resp_d[4] != req_q[7]) begin
                     status_d[3] = 1'b1;
                     resp_d[0]   = NONCE_ERR_CODE;
                  end
`endif
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
               if (idle_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  resp_d      = '{default: '0};
                  resp_d[0]   = TIMEOUT_CODE;
                  status_d[0] = 1'b1;
                  idle_cnt_d  = '0;
                  rcv_idx_d   = '0;
                  state_d     = RESP_READY;
               end
            end
         end
         RESP_READY: begin
            if (vm_resp_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // VM traffic outside IDLE is dropped but remembered.
      if (state_q != IDLE && (vm_req_we || vm_req_valid_set)) status_d[2] = 1'b1;
   end

   always_comb begin
      req_valid_d  = (state_d == SEND);
      req_word_d   = (state_d == SEND) ? req_d[send_idx_d] : '0;
      req_last_d   = (state_d == SEND) && (send_idx_d == 3'd7);
      resp_ready_d = (state_d == WAIT_RESP);
      resp_valid_d = (state_d == RESP_READY);
      busy_d       = (state_d != IDLE);
   end

   assign exec_req_valid  = req_valid_q;
   assign exec_req_word   = req_word_q;
   assign exec_req_last   = req_last_q;
   assign exec_resp_ready = resp_ready_q;
   assign vm_resp_valid   = resp_valid_q;
   assign busy            = busy_q;
   assign status          = status_q;
   assign vm_resp_w0      = resp_q[0];
   assign vm_resp_w1      = resp_q[1];
   assign vm_resp_w2      = resp_q[2];
   assign vm_resp_w3      = resp_q[3];
   assign vm_resp_w4      = resp_q[4];

endmodule

// File: tb/tb_boreal_mailbox_phaseb.sv
// Self-checking bench for boreal_mailbox_phaseb against a transaction-level mailbox model.
module tb_boreal_mailbox_phaseb;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        vm_req_we, vm_req_valid_set, vm_resp_ack;
   logic [3:0]  vm_req_widx;
   logic [31:0] vm_req_wdata;
   logic        vm_resp_valid;
   logic [31:0] vm_resp_w0, vm_resp_w1, vm_resp_w2, vm_resp_w3, vm_resp_w4;
   logic        exec_req_valid, exec_req_ready, exec_req_last;
   logic [31:0] exec_req_word;
   logic        exec_resp_valid, exec_resp_ready, exec_resp_last;
   logic [31:0] exec_resp_word;
   logic        busy;
   logic [3:0]  status;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_req  [8];
   logic [31:0] exp_resp [5];
   logic [3:0]  exp_status;

   boreal_mailbox_phaseb #(.TIMEOUT_CYCLES(TO), .TIMEOUT_CODE(32'hDEAD_0001)) dut (
      .clk(clk), .rst(rst),
      .vm_req_we(vm_req_we), .vm_req_widx(vm_req_widx), .vm_req_wdata(vm_req_wdata),
      .vm_req_valid_set(vm_req_valid_set),
      .vm_resp_valid(vm_resp_valid),
      .vm_resp_w0(vm_resp_w0), .vm_resp_w1(vm_resp_w1), .vm_resp_w2(vm_resp_w2),
      .vm_resp_w3(vm_resp_w3), .vm_resp_w4(vm_resp_w4),
      .vm_resp_ack(vm_resp_ack),
      .exec_req_valid(exec_req_valid), .exec_req_ready(exec_req_ready),
      .exec_req_word(exec_req_word), .exec_req_last(exec_req_last),
      .exec_resp_valid(exec_resp_valid), .exec_resp_ready(exec_resp_ready),
      .exec_resp_word(exec_resp_word), .exec_resp_last(exec_resp_last),
      .busy(busy), .status(status)
   );

   always #5 clk = ~clk;

   // Mailbox model of one completed response of n words.
   function automatic void model_complete(input logic [31:0] w [5], input int n);
      for (int i = 0; i < 5; i++) exp_resp[i] = (i < n) ? w[i] : 32'h0;
      if (n < 5) exp_status[1] = 1'b1;
`ifdef BOREAL_MB_NONCE_CHECK_EN
      if (exp_resp[4] != exp_req[7]) begin
         exp_resp[0]   = 32'hDEAD_0002;
         exp_status[3] = 1'b1;
      end
`endif
   endfunction

   task automatic write_req(input logic [3:0] idx, input logic [31:0] data);
      @(negedge clk);
      vm_req_we = 1'b1; vm_req_widx = idx; vm_req_wdata = data;
      if (idx < 8) exp_req[idx[2:0]] = data;
      @(negedge clk);
      vm_req_we = 1'b0;
   endtask

   task automatic start_req(input bit with_we, input logic [2:0] idx, input logic [31:0] data);
      @(negedge clk);
      vm_req_valid_set = 1'b1;
      if (with_we) begin
         vm_req_we = 1'b1; vm_req_widx = {1'b0, idx}; vm_req_wdata = data;
         exp_req[idx] = data;
      end
   endtask

   // mode 0: ready high, 1: toggle starting low, 2: random. poke: write widx 2 while sending.
   task automatic run_send(input int mode, input bit poke, output int cycles);
      int n = 0;
      int guard = 0;
      logic rdy;
      cycles = 0;
      while (n < 8 && guard < 200) begin
         @(negedge clk);
         guard++;
         vm_req_valid_set = 1'b0;
         vm_req_we = 1'b0;
         if (exec_req_valid) begin
            cycles++;
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cycles % 2 == 0) : 1'($urandom_range(0, 1));
            exec_req_ready = rdy;
            n_checks++;
            if (exec_req_word !== exp_req[n] || exec_req_last !== (n == 7)) begin
               n_fail++;
               $display("FAIL send_word[%0d]: got %h last=%b, expected %h last=%b",
                        n, exec_req_word, exec_req_last, exp_req[n], (n == 7));
            end
            if (poke && cycles == 2) begin
               vm_req_we = 1'b1; vm_req_widx = 4'd2; vm_req_wdata = 32'hFFFF;
               exp_status[2] = 1'b1;
            end
            if (rdy) n++;
         end else begin
            exec_req_ready = 1'b0;
         end
      end
      if (n < 8) begin
         n_fail++;
         $display("FAIL send_timeout: got %0d words, expected 8", n);
      end
      @(negedge clk);
      exec_req_ready = 1'b0;
      vm_req_we = 1'b0;
      n_checks++;
      if (exec_req_valid !== 1'b0 || exec_resp_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL enter_wait: got valid=%b resp_ready=%b busy=%b, expected 0 1 1",
                  exec_req_valid, exec_resp_ready, busy);
      end
   endtask

   // Executor returns n words with random gaps, last flagged on word n when set_last.
   task automatic run_resp(input logic [31:0] w [5], input int n, input bit set_last);
      logic [31:0] got [5];
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            exec_resp_valid = 1'b0; exec_resp_last = 1'b0;
         end
         @(negedge clk);
         exec_resp_valid = 1'b1; exec_resp_word = w[k];
         exec_resp_last = set_last && (k == n - 1);
      end
      model_complete(w, n);
      @(negedge clk);
      // A late executor word offered here must be refused.
      exec_resp_valid = 1'b1; exec_resp_word = 32'h1234_5678; exec_resp_last = 1'b1;
      n_checks++;
      if (vm_resp_valid !== 1'b1 || exec_resp_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_ready_state: got valid=%b resp_ready=%b busy=%b, expected 1 0 1",
                  vm_resp_valid, exec_resp_ready, busy);
      end
      @(negedge clk);
      exec_resp_valid = 1'b0; exec_resp_last = 1'b0;
      got = '{vm_resp_w0, vm_resp_w1, vm_resp_w2, vm_resp_w3, vm_resp_w4};
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (got[i] !== exp_resp[i]) begin
            n_fail++;
            $display("FAIL resp_w%0d: got %h expected %h", i, got[i], exp_resp[i]);
         end
      end
      n_checks++;
      if (status !== exp_status) begin
         n_fail++;
         $display("FAIL status_after_resp: got %b expected %b", status, exp_status);
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      vm_resp_ack = 1'b1;
      @(negedge clk);
      vm_resp_ack = 1'b0;
      n_checks++;
      if (vm_resp_valid !== 1'b0 || busy !== 1'b0 || vm_resp_w0 !== exp_resp[0]
          || vm_resp_w4 !== exp_resp[4]) begin
         n_fail++;
         $display("FAIL ack: got valid=%b busy=%b w0=%h w4=%h, expected 0 0 %h %h",
                  vm_resp_valid, busy, vm_resp_w0, vm_resp_w4, exp_resp[0], exp_resp[4]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vm_req_we = 0; vm_req_widx = 0; vm_req_wdata = 0; vm_req_valid_set = 0; vm_resp_ack = 0;
      exec_req_ready = 0; exec_resp_valid = 0; exec_resp_word = 0; exec_resp_last = 0;
      for (int i = 0; i < 8; i++) exp_req[i] = 32'h0;
      for (int i = 0; i < 5; i++) exp_resp[i] = 32'h0;
      exp_status = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({vm_resp_valid, exec_req_valid, exec_req_last, exec_resp_ready, busy} !== 5'b0
          || exec_req_word !== 32'h0 || status !== 4'h0
          || (vm_resp_w0 | vm_resp_w1 | vm_resp_w2 | vm_resp_w3 | vm_resp_w4) !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b req_valid=%b busy=%b status=%b w0=%h, expected all 0",
                  vm_resp_valid, exec_req_valid, busy, status, vm_resp_w0);
      end
      // Ack while idle has no effect.
      @(negedge clk) vm_resp_ack = 1'b1;
      @(negedge clk) vm_resp_ack = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || vm_resp_valid !== 1'b0 || status !== 4'h0) begin
         n_fail++;
         $display("FAIL idle_ack: got busy=%b valid=%b status=%b, expected 0 0 0000",
                  busy, vm_resp_valid, status);
      end
   endtask

   task automatic test_normal();
      logic [31:0] init [8] = '{32'h1, 32'h10, 32'h64, 32'h0, 32'h0, 32'hA5A5_0001, 32'h0, 32'h5};
      int cyc;
      for (int i = 0; i < 7; i++) write_req(4'(i), init[i]);
      start_req(1'b1, 3'd7, init[7]);
      run_send(0, 1'b0, cyc);
      n_checks++;
      if (cyc !== 8) begin
         n_fail++;
         $display("FAIL send_cycles_ready_high: got %0d expected 8", cyc);
      end
      run_resp('{32'hA, 32'hB, 32'hC, 32'hD, 32'h5}, 5, 1'b1);
      do_ack();
   endtask

   task automatic test_backpressure();
      int cyc;
      write_req(4'd9, 32'hBAD0_BAD0);
      start_req(1'b0, 3'd0, 32'h0);
      run_send(1, 1'b0, cyc);
      n_checks++;
      if (cyc !== 16) begin
         n_fail++;
         $display("FAIL send_cycles_toggle: got %0d expected 16", cyc);
      end
      run_resp('{32'h11, 32'h22, 32'h33, 32'h44, exp_req[7]}, 5, 1'b0);
      do_ack();
   endtask

   task automatic test_short_response();
      int cyc;
      start_req(1'b0, 3'd0, 32'h0);
      run_send(0, 1'b0, cyc);
      run_resp('{32'h7, 32'h8, 32'h0, 32'h0, 32'h0}, 2, 1'b1);
      do_ack();
   endtask

   task automatic test_busy_drop();
      int cyc;
      start_req(1'b0, 3'd0, 32'h0);
      run_send(0, 1'b1, cyc);
      @(negedge clk) vm_req_valid_set = 1'b1;
      exp_status[2] = 1'b1;
      @(negedge clk) vm_req_valid_set = 1'b0;
      run_resp('{32'h21, 32'h22, 32'h23, 32'h24, exp_req[7]}, 5, 1'b1);
      do_ack();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (exec_req_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_second_transfer: got req_valid=%b busy=%b, expected 0 0",
                     exec_req_valid, busy);
         end
      end
   endtask

   task automatic test_nonce();
      int cyc;
      write_req(4'd7, 32'h5);
      start_req(1'b0, 3'd0, 32'h0);
      run_send(0, 1'b0, cyc);
      run_resp('{32'h31, 32'h32, 32'h33, 32'h34, 32'h6}, 5, 1'b1);
      do_ack();
   endtask

   task automatic test_random();
      int cyc;
      int n;
      logic [31:0] w [5];
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 4; k++) write_req(4'($urandom_range(0, 15)), $urandom);
         start_req(1'b1, 3'($urandom_range(0, 7)), $urandom);
         run_send(2, 1'b0, cyc);
         n = $urandom_range(1, 5);
         for (int i = 0; i < 5; i++) w[i] = $urandom;
         if ($urandom_range(0, 1) == 1) w[4] = exp_req[7];
         run_resp(w, n, (n < 5) ? 1'b1 : 1'($urandom_range(0, 1)));
         do_ack();
      end
   endtask

   task automatic test_reset_mid();
      start_req(1'b0, 3'd0, 32'h0);
      @(negedge clk);
      vm_req_valid_set = 1'b0;
      exec_req_ready = 1'b1;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (exec_req_valid !== 1'b0 || exec_resp_ready !== 1'b0 || busy !== 1'b0
          || status !== 4'h0 || vm_resp_w0 !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got req_valid=%b resp_ready=%b busy=%b status=%b w0=%h, expected 0",
                  exec_req_valid, exec_resp_ready, busy, status, vm_resp_w0);
      end
      exec_req_ready = 1'b0;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 8; i++) exp_req[i] = 32'h0;
      for (int i = 0; i < 5; i++) exp_resp[i] = 32'h0;
      exp_status = 4'h0;
   endtask

   task automatic test_timeout();
      int cyc;
      int waits = 0;
      logic [31:0] got [5];
      write_req(4'd3, 32'h3333);
      start_req(1'b0, 3'd0, 32'h0);
      run_send(0, 1'b0, cyc);
      waits = 1;
      while (!vm_resp_valid && waits < 100) begin
         @(negedge clk);
         if (exec_resp_ready) waits++;
      end
      n_checks++;
      if (waits !== TO || vm_resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d wait cycles valid=%b, expected %0d 1",
                  waits, vm_resp_valid, TO);
      end
      exp_resp = '{32'hDEAD_0001, 32'h0, 32'h0, 32'h0, 32'h0};
      exp_status[0] = 1'b1;
      got = '{vm_resp_w0, vm_resp_w1, vm_resp_w2, vm_resp_w3, vm_resp_w4};
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (got[i] !== exp_resp[i]) begin
            n_fail++;
            $display("FAIL timeout_w%0d: got %h expected %h", i, got[i], exp_resp[i]);
         end
      end
      n_checks++;
      if (status !== 4'b0001) begin
         n_fail++;
         $display("FAIL timeout_status: got %b expected 0001", status);
      end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_short_response();
      test_busy_drop();
      test_nonce();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
